// File: rtl/div_pkg.sv
// Shared types and constants for the sequential 32/16 signed divider.
package div_pkg;

  localparam int unsigned DIVIDEND_W = 32;
  localparam int unsigned DIVISOR_W  = 16;
  localparam int unsigned CNT_W      = 5;

  localparam logic [DIVISOR_W-1:0] Q_MAX = 16'h7FFF;
  localparam logic [DIVISOR_W-1:0] Q_MIN = 16'h8000;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ITER,
    FIX,
    DONE
  } div_state_e;

  typedef struct packed {
    logic [DIVISOR_W-1:0] q;
    logic [DIVISOR_W-1:0] r;
    logic                 dz;
    logic                 ovf;
  } div_res_t;

  // Saturated quotient for a given result sign.
  function automatic logic [DIVISOR_W-1:0] sat_q(input logic neg);
    return neg ? Q_MIN : Q_MAX;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step on the shifted partial remainder.
module div_step
  import div_pkg::*;
(
  input  logic [DIVISOR_W:0]   rem_i,
  input  logic [DIVISOR_W-1:0] dabs_i,
  output logic [DIVISOR_W-1:0] rem_o,
  output logic                 q_bit_o
);

  // rem_i < 2*|d| always holds, so a kept or restored remainder fits in 16 bits.
  always_comb begin
    q_bit_o = (rem_i >= {1'b0, dabs_i});
    rem_o   = q_bit_o ? DIVISOR_W'(rem_i - {1'b0, dabs_i}) : rem_i[DIVISOR_W-1:0];
  end

endmodule

// File: rtl/seq_div32by16.sv
// Sequential signed 32/16 restoring divider with valid/ready handshakes.
// Define APPROX_DIV_EN to skip the low APPROX_BITS quotient iterations.
module seq_div32by16
  import div_pkg::*;
#(
  parameter int unsigned APPROX_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] x,
  input  logic [DIVISOR_W-1:0]  d,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVISOR_W-1:0]  q,
  output logic [DIVISOR_W-1:0]  r,
  output logic                  dz,
  output logic                  ovf
);

`ifdef APPROX_DIV_EN
  localparam bit APPROX_EN = 1'b1;
`else
  localparam bit APPROX_EN = 1'b0;
`endif
  localparam int unsigned SKIP  = APPROX_EN ? APPROX_BITS : 0;
  localparam int unsigned ITERS = DIVISOR_W - SKIP;

  div_state_e            state_q, state_d;
  logic [DIVIDEND_W-1:0] x_q, x_d;
  logic [DIVISOR_W-1:0]  d_q, d_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic [DIVISOR_W-1:0]  lo_q, lo_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  qneg_q, qneg_d;
  logic                  rneg_q, rneg_d;
  div_res_t              res_q, res_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;

  logic [DIVIDEND_W-1:0] xabs_c;
  logic [DIVISOR_W-1:0]  dabs_c;
  logic [DIVISOR_W-1:0]  step_rem_c;
  logic                  step_qbit_c;
  logic [DIVISOR_W-1:0]  qmag_c;
  logic [DIVISOR_W-1:0]  rmag_c;

  div_step u_step (
    .rem_i   ({rem_q, lo_q[DIVISOR_W-1]}),
    .dabs_i  (dabs_c),
    .rem_o   (step_rem_c),
    .q_bit_o (step_qbit_c)
  );

  // Magnitudes; -2^31 maps to 2^31 as an unsigned 32-bit value.
  always_comb begin
    xabs_c = x_q[DIVIDEND_W-1] ? DIVIDEND_W'(-x_q) : x_q;
    dabs_c = d_q[DIVISOR_W-1]  ? DIVISOR_W'(-d_q)  : d_q;
    // Skipped iterations leave unconsumed dividend bits in lo_q; they fold into r.
    qmag_c = DIVISOR_W'(lo_q << SKIP);
    rmag_c = DIVISOR_W'({rem_q, lo_q} >> ITERS);
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    d_d         = d_q;
    rem_d       = rem_q;
    lo_d        = lo_q;
    cnt_d       = cnt_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    res_d       = res_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d        = x;
          d_d        = d;
          in_ready_d = 1'b0;
          state_d    = LOAD;
        end
      end

      LOAD: begin
        qneg_d = x_q[DIVIDEND_W-1] ^ d_q[DIVISOR_W-1];
        rneg_d = x_q[DIVIDEND_W-1];
        if (d_q == '0) begin
          res_d       = '{q: sat_q(x_q[DIVIDEND_W-1]), r: '0, dz: 1'b1, ovf: 1'b0};
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else if (xabs_c[DIVIDEND_W-1:DIVISOR_W] >= dabs_c) begin
          res_d       = '{q: sat_q(x_q[DIVIDEND_W-1] ^ d_q[DIVISOR_W-1]), r: '0,
                          dz: 1'b0, ovf: 1'b1};
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          rem_d   = xabs_c[DIVIDEND_W-1:DIVISOR_W];
          lo_d    = xabs_c[DIVISOR_W-1:0];
          cnt_d   = '0;
          state_d = ITER;
        end
      end

      ITER: begin
        rem_d = step_rem_c;
        lo_d  = {lo_q[DIVISOR_W-2:0], step_qbit_c};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITERS - 1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
        if (qneg_q ? (qmag_c > Q_MIN) : qmag_c[DIVISOR_W-1]) begin
          res_d = '{q: sat_q(qneg_q), r: '0, dz: 1'b0, ovf: 1'b1};
        end else begin
          res_d = '{q: qneg_q ? DIVISOR_W'(-qmag_c) : qmag_c,
                    r: rneg_q ? DIVISOR_W'(-rmag_c) : rmag_c,
                    dz: 1'b0, ovf: 1'b0};
        end
        out_valid_d = 1'b1;
        state_d     = DONE;
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      d_q         <= '0;
      rem_q       <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      res_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      d_q         <= d_d;
      rem_q       <= rem_d;
      lo_q        <= lo_d;
      cnt_q       <= cnt_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      res_q       <= res_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign q         = res_q.q;
  assign r         = res_q.r;
  assign dz        = res_q.dz;
  assign ovf       = res_q.ovf;

endmodule

// File: tb/tb_seq_div32by16.sv
// Directed vector bench for seq_div32by16 (exact build; approximate build under APPROX_DIV_EN).
module tb_seq_div32by16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic [15:0] d;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] q;
  logic [15:0] r;
  logic        dz;
  logic        ovf;

  always #5 clk = ~clk;

  seq_div32by16 #(.APPROX_BITS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .r         (r),
    .dz        (dz),
    .ovf       (ovf)
  );

  typedef struct {
    logic [31:0] x;
    logic [15:0] d;
    logic [15:0] eq;
    logic [15:0] er;
    logic        edz;
    logic        eovf;
    int          elat;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] vx, input logic [15:0] vd, input logic [15:0] vq,
                     input logic [15:0] vr, input logic vdz, input logic vovf, input int vlat);
    vec_t v;
    v.x = vx; v.d = vd; v.eq = vq; v.er = vr; v.edz = vdz; v.eovf = vovf; v.elat = vlat;
    vecs.push_back(v);
  endtask

  // Drive one request on the accept edge (E0); return edges until out_valid is seen.
  task automatic start_op(input logic [31:0] vx, input logic [15:0] vd);
    x = vx;
    d = vd;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) check({tag, " timeout"}, 32'(out_valid), 32'd1);
  endtask

  task automatic run_vec(input int idx);
    vec_t  v;
    int    lat;
    string tag;
    v   = vecs[idx];
    tag = $sformatf("vec%0d", idx);
    check({tag, " in_ready before"}, 32'(in_ready), 32'd1);
    start_op(v.x, v.d);
    wait_valid(tag, lat);
    check({tag, " latency"}, 32'(lat), 32'(v.elat));
    check({tag, " q"}, 32'(q), 32'(v.eq));
    check({tag, " r"}, 32'(r), 32'(v.er));
    check({tag, " dz"}, 32'(dz), 32'(v.edz));
    check({tag, " ovf"}, 32'(ovf), 32'(v.eovf));
    check({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = '0;
    d         = '0;

`ifdef APPROX_DIV_EN
    add(32'd1000,       16'd7,      16'h0080, 16'h0068, 1'b0, 1'b0, 14);
    add(32'hFFFFFC18,   16'd7,      16'hFF80, 16'hFF98, 1'b0, 1'b0, 14);
    add(32'd5,          16'd0,      16'h7FFF, 16'h0000, 1'b1, 1'b0, 1);
    add(32'hFFFFFFFB,   16'd0,      16'h8000, 16'h0000, 1'b1, 1'b0, 1);
    add(32'h7FFFFFFF,   16'd1,      16'h7FFF, 16'h0000, 1'b0, 1'b1, 1);
    add(32'h80000000,   16'h8000,   16'h7FFF, 16'h0000, 1'b0, 1'b1, 1);
    add(32'd0,          16'd5,      16'h0000, 16'h0000, 1'b0, 1'b0, 14);
`else
    add(32'd1000,       16'd7,      16'h008E, 16'h0006, 1'b0, 1'b0, 18);
    add(32'hFFFFFC18,   16'd7,      16'hFF72, 16'hFFFA, 1'b0, 1'b0, 18);
    add(32'd1000,       16'hFFF9,   16'hFF72, 16'h0006, 1'b0, 1'b0, 18);
    add(32'hFFFFFC18,   16'hFFF9,   16'h008E, 16'hFFFA, 1'b0, 1'b0, 18);
    add(32'h7FFFFFFF,   16'd1,      16'h7FFF, 16'h0000, 1'b0, 1'b1, 1);
    add(32'hFFFF8000,   16'd1,      16'h8000, 16'h0000, 1'b0, 1'b0, 18);
    add(32'd5,          16'd0,      16'h7FFF, 16'h0000, 1'b1, 1'b0, 1);
    add(32'hFFFFFFFB,   16'd0,      16'h8000, 16'h0000, 1'b1, 1'b0, 1);
    add(32'h00008000,   16'd1,      16'h7FFF, 16'h0000, 1'b0, 1'b1, 18);
    add(32'h80000000,   16'h8000,   16'h7FFF, 16'h0000, 1'b0, 1'b1, 1);
    add(32'h000186A0,   16'd3,      16'h7FFF, 16'h0000, 1'b0, 1'b1, 18);
    add(32'hFFFE7960,   16'd3,      16'h8000, 16'h0000, 1'b0, 1'b1, 18);
    add(32'h075BCD15,   16'hCFC7,   16'hD8F0, 16'h1A85, 1'b0, 1'b0, 18);
    add(32'hFFFFFFFF,   16'd1,      16'hFFFF, 16'h0000, 1'b0, 1'b0, 18);
    add(32'd7,          16'd1000,   16'h0000, 16'h0007, 1'b0, 1'b0, 18);
    add(32'd0,          16'd5,      16'h0000, 16'h0000, 1'b0, 1'b0, 18);
`endif

    #12;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset q", 32'(q), 32'd0);
    check("reset r", 32'(r), 32'd0);
    check("reset dz", 32'(dz), 32'd0);
    check("reset ovf", 32'(ovf), 32'd0);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) run_vec(i);

    // Backpressure: result held, new requests ignored while DONE.
    start_op(vecs[0].x, vecs[0].d);
    wait_valid("bp", lat);
    for (int c = 0; c < 5; c++) begin
      x = 32'd5;
      d = 16'd0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("bp%0d out_valid", c), 32'(out_valid), 32'd1);
      check($sformatf("bp%0d in_ready", c), 32'(in_ready), 32'd0);
      check($sformatf("bp%0d q", c), 32'(q), 32'(vecs[0].eq));
      check($sformatf("bp%0d r", c), 32'(r), 32'(vecs[0].er));
      check($sformatf("bp%0d dz", c), 32'(dz), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp release out_valid", 32'(out_valid), 32'd0);
    check("bp release in_ready", 32'(in_ready), 32'd1);

    // Leave a divide-by-zero result on the outputs, then reset in the middle of ITER.
    start_op(32'd5, 16'd0);
    wait_valid("dz prime", lat);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    start_op(32'hFFFFFC18, 16'd7);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check("mid-iter out_valid", 32'(out_valid), 32'd0);
    check("mid-iter q held", 32'(q), 32'h7FFF);
    check("mid-iter dz held", 32'(dz), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async rst out_valid", 32'(out_valid), 32'd0);
    check("async rst in_ready", 32'(in_ready), 32'd1);
    check("async rst q", 32'(q), 32'd0);
    check("async rst r", 32'(r), 32'd0);
    check("async rst dz", 32'(dz), 32'd0);
    check("async rst ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post rst out_valid", 32'(out_valid), 32'd0);
    run_vec(0);
    run_vec(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
